// File: rtl/serial_en_tx.sv
// serial_en_tx: parallel-to-serial transmitter with a data qualifier.
// A word is accepted with valid/ready, then sent LSB first on d.
// en marks each cycle that carries a real bit. done pulses for one cycle at
// the end of a frame.
// Optional feature: define PARITY_EN to append one even-parity bit to each
// frame.
//
// Handshake: a word moves on a rising clk edge only when valid=1 and ready=1.
// ready is high only in IDLE. valid is ignored in every other state, and
// nothing is queued.
//
// Hold: hold is sampled on the same edges as everything else, so it takes
// effect one cycle later.
// - If a bit is on d (en=1) on the edge where hold is sampled high, that bit
//   counts as delivered.
// - The following cycles show en=0, and d keeps that bit's value until hold
//   drops.

module serial_en_tx #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] din,
    input  logic             valid,
    output logic             ready,
    input  logic             hold,
    output logic             d,
    output logic             en,
    output logic             done,
    output logic [1:0]       fsm_state
);

    localparam int CW = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH);
    localparam logic [CW-1:0] ONE  = CW'(1);

`ifdef PARITY_EN
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        PARITY = 2'd2,
        DONE   = 2'd3
    } state_t;
`else
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        DONE   = 2'd3
    } state_t;
`endif

    state_t           state;
    logic [WIDTH-1:0] sr;    // sr[0] is the bit currently on d while en=1
    logic [CW-1:0]    cnt;   // number of data bits already delivered
`ifdef PARITY_EN
    logic             par;   // even parity of the captured word
`endif

    assign fsm_state = state;

    // Frame sequencer. Every output is a register that is updated here.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
            sr    <= '0;
            cnt   <= '0;
            d     <= 1'b0;
            en    <= 1'b0;
            done  <= 1'b0;
            ready <= 1'b1;
`ifdef PARITY_EN
            par   <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    // hold has no effect here. The first bit always goes
                    // out in the very next cycle.
                    if (valid && ready) begin
                        sr    <= din;
                        cnt   <= '0;
                        d     <= din[0];
                        en    <= 1'b1;
                        ready <= 1'b0;
                        state <= SHIFT;
`ifdef PARITY_EN
                        par   <= ^din;
`endif
                    end else begin
                        d     <= 1'b0;
                        en    <= 1'b0;
                        ready <= 1'b1;
                    end
                end

                SHIFT: begin
                    if (en) begin
                        // The bit on d is delivered on this edge.
                        sr  <= sr >> 1;
                        cnt <= cnt + ONE;
                        if (cnt + ONE == LAST) begin
`ifdef PARITY_EN
                            state <= PARITY;
                            if (hold) begin
                                en <= 1'b0;
                            end else begin
                                en <= 1'b1;
                                d  <= par;
                            end
`else
                            state <= DONE;
                            en    <= 1'b0;
                            d     <= 1'b0;
                            done  <= 1'b1;
`endif
                        end else if (hold) begin
                            en <= 1'b0;
                        end else begin
                            en <= 1'b1;
                            d  <= sr[1];
                        end
                    end else if (!hold) begin
                        // Resume from a pause. The next undelivered bit is
                        // still in sr[0].
                        en <= 1'b1;
                        d  <= sr[0];
                    end
                end

`ifdef PARITY_EN
                PARITY: begin
                    if (en) begin
                        state <= DONE;
                        en    <= 1'b0;
                        d     <= 1'b0;
                        done  <= 1'b1;
                    end else if (!hold) begin
                        en <= 1'b1;
                        d  <= par;
                    end
                end
`endif

                DONE: begin
                    // This state always lasts exactly one cycle, whatever
                    // hold does.
                    done  <= 1'b0;
                    en    <= 1'b0;
                    d     <= 1'b0;
                    ready <= 1'b1;
                    cnt   <= '0;
                    state <= IDLE;
                end

                default: begin
                    state <= IDLE;
                    en    <= 1'b0;
                    d     <= 1'b0;
                    done  <= 1'b0;
                    ready <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: doc/serial_en_tx.md
SERIAL_EN_TX -- requirements
Module: serial_en_tx

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-002 Parameter: WIDTH, default 8, word length in bits; legal range 2..32.
REQ-003 Port: clk  input  1  rising-edge clock.
REQ-004 Port: reset_n  input  1  asynchronous active-low reset.
REQ-005 Port: din  input  WIDTH  parallel word to transmit.
REQ-006 Port: valid  input  1  din holds a word to send.
REQ-007 Port: ready  output  1  block accepts a word this cycle.
REQ-008 Port: hold  input  1  pause request; freezes shifting.
REQ-009 Port: d  output  1  serial data bit, LSB first.
REQ-010 Port: en  output  1  d qualifier; receiver captures d on a clk edge only when en=1.
REQ-011 Port: done  output  1  one-cycle pulse after the last bit of a frame.

Function
REQ-012 The state machine SHALL have the states IDLE, SHIFT, PARITY (only with PARITY_EN) and DONE.
REQ-013 All outputs SHALL be registered.
REQ-014 IDLE: ready=1, en=0, d=0, done=0.
REQ-015 A word SHALL be accepted on a rising edge with valid=1 and ready=1. Accept: capture din into the shift register, clear the bit counter, go to SHIFT.
REQ-016 SHIFT with hold=0: en=1, d=current LSB of the shift register. On the edge, shift right and increment the counter.
REQ-017 The first en=1 cycle SHALL be the cycle immediately after the accept edge, giving 1-cycle latency.
REQ-018 SHIFT with hold=1: en=0, d keeps its last value, and the counter and shift register stay frozen. Asserting hold SHALL NOT drop, repeat or reorder any bit.
REQ-019 After exactly WIDTH en=1 cycles, SHIFT SHALL go to PARITY if PARITY_EN is defined, otherwise to DONE.
REQ-020 DONE: en=0, done=1, ready=0, held for exactly one cycle, then return to IDLE. hold has no effect in DONE.
REQ-021 ready SHALL be 0 in SHIFT, PARITY and DONE. valid in those states SHALL be ignored and no word is lost or queued.
REQ-022 A change on din after the accept edge SHALL NOT affect the frame in flight.
REQ-023 Back-to-back frames: the minimum accept-to-accept spacing SHALL be WIDTH+2 cycles without parity and WIDTH+3 with parity. No en=1 cycle may occur outside SHIFT or PARITY.
REQ-024 hold in IDLE SHALL NOT affect ready or accept.
REQ-025 The bit counter SHALL be $clog2(WIDTH)+1 bits wide and SHALL NOT wrap within a frame.

Reset
REQ-026 reset_n=0 SHALL immediately force state=IDLE, d=0, en=0, done=0, ready=1, and clear the counter and shift register.
REQ-027 Reset asserted mid-frame SHALL abort the frame with no done pulse. After release, the first valid=1 edge SHALL start a fresh frame from bit 0.
REQ-028 The first accept SHALL be possible on the first rising edge after reset_n deasserts.

Configuration
REQ-029 The macro PARITY_EN SHALL select parity generation.
REQ-030 With PARITY_EN defined: after the WIDTH data bits, the PARITY state SHALL drive one en=1 cycle with d equal to the XOR of the captured word (even parity). hold freezes PARITY exactly as in SHIFT.
REQ-031 Without PARITY_EN: no PARITY state exists, and a frame is exactly WIDTH en=1 cycles.

Verification
REQ-032 WIDTH=8, no PARITY_EN: accept 8'hA5 with hold=0 -> en=1 for 8 cycles with d=1,0,1,0,0,1,0,1; then done=1 for one cycle; then ready=1.
REQ-033 PARITY_EN: accept 8'h07 -> d=1,1,1,0,0,0,0,0, then parity d=1 with en=1; done the following cycle. Accept 8'h03 -> parity d=0.
REQ-034 Accept 8'hF0; hold=1 for 3 cycles after the 2nd bit -> en=0 for those 3 cycles with d held at 0. Resume gives 0,0,1,1,1,1 with a total of 8 en=1 cycles.
REQ-035 Keep valid=1 continuously with din=8'h01 then 8'h80 -> accepts only in IDLE, spacing 10 cycles without parity. din change mid-frame is not reflected on d.
REQ-036 Assert reset_n=0 after the 4th bit of 8'hFF -> en=0, d=0, ready=1 immediately, and no done. Next accept of 8'h01 gives d=1 then 0,0,0,0,0,0,0.
